// File: rtl/ddram_responder_if.sv
// ----------------------------------------------------------------------------
// ddram_responder_if
// Bundles the 64-bit DDRAM burst bus between the core-side arbiter (master)
// and a memory-side responder (slave).
//   DDRAM_BUSY        : waitrequest, driven by the slave
//   DDRAM_BURSTCNT    : beats in the burst (0 means 1)
//   DDRAM_ADDR        : 64-bit word address of the first beat
//   DDRAM_RD/WE       : read command / write beat strobes
//   DDRAM_DIN/BE      : write data and byte enables
//   DDRAM_DOUT        : read data, driven by the slave
//   DDRAM_DOUT_READY  : read beat valid, driven by the slave
// ----------------------------------------------------------------------------
interface ddram_responder_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;

    modport master (
        input  DDRAM_BUSY,
        input  DDRAM_DOUT,
        input  DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT,
        output DDRAM_ADDR,
        output DDRAM_RD,
        output DDRAM_WE,
        output DDRAM_DIN,
        output DDRAM_BE
    );

    modport slave (
        output DDRAM_BUSY,
        output DDRAM_DOUT,
        output DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT,
        input  DDRAM_ADDR,
        input  DDRAM_RD,
        input  DDRAM_WE,
        input  DDRAM_DIN,
        input  DDRAM_BE
    );
endinterface

// File: rtl/ddram_responder.sv
// ----------------------------------------------------------------------------
// ddram_responder
// Memory-side responder for the 64-bit DDRAM burst bus. Accepted commands go
// into a command queue (write beats also into a data queue); an in-order
// engine commits writes into an on-chip word array and streams read beats out
// through a fixed-latency pipe.
//
// Ports:
//   DDRAM_CLK      : clock, rising edge
//   DDRAM_RESET_N  : asynchronous active-low reset
//   bus            : ddram_responder_if.slave (BUSY, BURSTCNT, ADDR, RD, WE,
//                    DIN, BE, DOUT, DOUT_READY)
//
// Optional feature macro: DDRAM_RESP_STALL_EN
//   When defined, a 16-bit LFSR injects extra BUSY cycles for stress testing.
// ----------------------------------------------------------------------------
module ddram_responder #(
    parameter int MEM_AW    = 12,
    parameter int CMD_DEPTH = 4,
    parameter int DAT_DEPTH = 8,
    parameter int RD_LAT    = 3
) (
    input  logic             DDRAM_CLK,
    input  logic             DDRAM_RESET_N,
    ddram_responder_if.slave bus
);

    localparam int CA_W = $clog2(CMD_DEPTH);
    localparam int DA_W = $clog2(DAT_DEPTH);
    localparam int CC_W = CA_W + 1;
    localparam int DC_W = DA_W + 1;
    localparam int E_W  = MEM_AW + 9;      // {is_write, addr, n}
    localparam int PIPE = RD_LAT - 2;      // array register + extra delay stages

    localparam logic [CC_W-1:0] CMD_FULL = CC_W'(CMD_DEPTH);
    localparam logic [DC_W-1:0] DAT_FULL = DC_W'(DAT_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // ---------------- storage ----------------
    logic [63:0]       r_mem [1<<MEM_AW];
    logic [E_W-1:0]    r_cmd_q [CMD_DEPTH];
    logic [71:0]       r_dat_q [DAT_DEPTH];
    logic [63:0]       r_pipe_dat [PIPE];

    // ---------------- registers ----------------
    logic [CA_W-1:0]   r_cmd_wp, r_cmd_rp;
    logic [CC_W-1:0]   r_cmd_cnt;
    logic [DA_W-1:0]   r_dat_wp, r_dat_rp;
    logic [DC_W-1:0]   r_dat_cnt;
    logic              r_busy;
    logic              r_wr_open;
    logic [7:0]        r_wr_left;
    logic [1:0]        r_state;
    logic [MEM_AW-1:0] r_eng_addr;
    logic [7:0]        r_eng_left;
    logic [PIPE-1:0]   r_pipe_vld;
    logic [63:0]       r_dout;
    logic              r_dout_rdy;

    // ---------------- wires ----------------
    logic [7:0]        w_burst_n;
    logic              w_wr_acc, w_rd_acc;
    logic              w_cmd_push, w_dat_push, w_cmd_pop, w_dat_pop, w_rd_issue;
    logic [E_W-1:0]    w_cmd_entry, w_cmd_head;
    logic              w_head_wr;
    logic [MEM_AW-1:0] w_head_addr;
    logic [7:0]        w_head_n;
    logic [71:0]       w_dat_head;
    logic [CC_W-1:0]   w_cmd_cnt_nxt;
    logic [DC_W-1:0]   w_dat_cnt_nxt;
    logic              w_stall;
    logic              w_unused_addr;

    // Upper address bits are don't-care: the array is modulo 2^MEM_AW.
    assign w_unused_addr = ^bus.DDRAM_ADDR[28:MEM_AW];

    // A burst count of zero is treated as a single beat.
    always_comb begin
        w_burst_n = bus.DDRAM_BURSTCNT;
        if (bus.DDRAM_BURSTCNT == 8'd0) begin
            w_burst_n = 8'd1;
        end else begin
            w_burst_n = bus.DDRAM_BURSTCNT;
        end
    end

    // Write wins over a simultaneous read; reads inside an open write burst drop.
    assign w_wr_acc    = !r_busy && bus.DDRAM_WE;
    assign w_rd_acc    = !r_busy && bus.DDRAM_RD && !bus.DDRAM_WE && !r_wr_open;
    assign w_cmd_push  = (w_wr_acc && !r_wr_open) || w_rd_acc;
    assign w_dat_push  = w_wr_acc;
    assign w_cmd_entry = {w_wr_acc, bus.DDRAM_ADDR[MEM_AW-1:0], w_burst_n};

    assign w_cmd_head  = r_cmd_q[r_cmd_rp];
    assign w_head_wr   = w_cmd_head[E_W-1];
    assign w_head_addr = w_cmd_head[E_W-2:8];
    assign w_head_n    = w_cmd_head[7:0];
    assign w_dat_head  = r_dat_q[r_dat_rp];

    // A read that is issuing its last beat may chain straight into a queued
    // read so consecutive read bursts leave the pipe without bubbles.
    assign w_cmd_pop  = (r_cmd_cnt != {CC_W{1'b0}}) &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_READ) && (r_eng_left == 8'd1) && !w_head_wr));
    assign w_dat_pop  = (r_state == ST_WRITE) && (r_dat_cnt != {DC_W{1'b0}});
    assign w_rd_issue = (r_state == ST_READ);

    assign w_cmd_cnt_nxt = r_cmd_cnt + CC_W'(w_cmd_push) - CC_W'(w_cmd_pop);
    assign w_dat_cnt_nxt = r_dat_cnt + DC_W'(w_dat_push) - DC_W'(w_dat_pop);

`ifdef DDRAM_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // Free-running stall pattern generator.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
    // BUSY is registered, so look at the value the LFSR will hold next cycle.
    assign w_stall = (w_lfsr_nxt[2:0] == 3'd0);
`else
    assign w_stall = 1'b0;
`endif

    // Waitrequest from post-update fullness so no accepted beat is ever lost.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_cmd_cnt_nxt == CMD_FULL) | (w_dat_cnt_nxt == DAT_FULL) | w_stall;
        end
    end

    // Tracks the remaining data-only beats of an open write burst.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_wr_open <= 1'b0;
            r_wr_left <= 8'd0;
        end else if (w_wr_acc) begin
            if (!r_wr_open) begin
                if (w_burst_n != 8'd1) begin
                    r_wr_open <= 1'b1;
                    r_wr_left <= w_burst_n - 8'd1;
                end
            end else begin
                r_wr_left <= r_wr_left - 8'd1;
                if (r_wr_left == 8'd1) begin
                    r_wr_open <= 1'b0;
                end
            end
        end
    end

    // Queue payload storage (no reset needed, guarded by the counts).
    always_ff @(posedge DDRAM_CLK) begin
        if (w_cmd_push) begin
            r_cmd_q[r_cmd_wp] <= w_cmd_entry;
        end
        if (w_dat_push) begin
            r_dat_q[r_dat_wp] <= {bus.DDRAM_BE, bus.DDRAM_DIN};
        end
    end

    // Queue pointers and occupancy counts.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_cmd_wp  <= {CA_W{1'b0}};
            r_cmd_rp  <= {CA_W{1'b0}};
            r_cmd_cnt <= {CC_W{1'b0}};
            r_dat_wp  <= {DA_W{1'b0}};
            r_dat_rp  <= {DA_W{1'b0}};
            r_dat_cnt <= {DC_W{1'b0}};
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CA_W'(1);
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CA_W'(1);
            if (w_dat_push) r_dat_wp <= r_dat_wp + DA_W'(1);
            if (w_dat_pop)  r_dat_rp <= r_dat_rp + DA_W'(1);
            r_cmd_cnt <= w_cmd_cnt_nxt;
            r_dat_cnt <= w_dat_cnt_nxt;
        end
    end

    // In-order execution engine.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_state    <= ST_IDLE;
            r_eng_addr <= {MEM_AW{1'b0}};
            r_eng_left <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_pop) begin
                        r_state    <= w_head_wr ? ST_WRITE : ST_READ;
                        r_eng_addr <= w_head_addr;
                        r_eng_left <= w_head_n;
                    end
                end
                ST_WRITE: begin
                    if (w_dat_pop) begin
                        r_eng_addr <= r_eng_addr + MEM_AW'(1);
                        r_eng_left <= r_eng_left - 8'd1;
                        if (r_eng_left == 8'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    r_eng_addr <= r_eng_addr + MEM_AW'(1);
                    r_eng_left <= r_eng_left - 8'd1;
                    if (r_eng_left == 8'd1) begin
                        if (w_cmd_pop) begin
                            r_eng_addr <= w_head_addr;
                            r_eng_left <= w_head_n;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_pipe_vld == {PIPE{1'b0}}) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word array with byte-lane writes, plus the read data pipe.
    always_ff @(posedge DDRAM_CLK) begin
        if (w_dat_pop) begin
            for (int b = 0; b < 8; b++) begin
                if (w_dat_head[64+b]) begin
                    r_mem[r_eng_addr][8*b +: 8] <= w_dat_head[8*b +: 8];
                end
            end
        end
        if (w_rd_issue) begin
            r_pipe_dat[0] <= r_mem[r_eng_addr];
        end
        for (int k = 1; k < PIPE; k++) begin
            r_pipe_dat[k] <= r_pipe_dat[k-1];
        end
    end

    // Read-beat valid pipe; reset abandons any in-flight beats.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_pipe_vld <= {PIPE{1'b0}};
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            for (int k = 1; k < PIPE; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
            end
        end
    end

    // Output register; DOUT holds its last value between beats.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) begin
            r_dout     <= 64'd0;
            r_dout_rdy <= 1'b0;
        end else begin
            r_dout_rdy <= r_pipe_vld[PIPE-1];
            if (r_pipe_vld[PIPE-1]) begin
                r_dout <= r_pipe_dat[PIPE-1];
            end
        end
    end

    assign bus.DDRAM_BUSY       = r_busy;
    assign bus.DDRAM_DOUT       = r_dout;
    assign bus.DDRAM_DOUT_READY = r_dout_rdy;

endmodule

// File: tb/tb_ddram_responder.sv
// ----------------------------------------------------------------------------
// tb_ddram_responder
// Directed self-checking bench for ddram_responder (MEM_AW=5, CMD_DEPTH=4,
// DAT_DEPTH=8, RD_LAT=3). Read beats are collected with their cycle numbers
// and compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ddram_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   busy_seen = 1'b0;
    logic [63:0] beat_q[$];
    int          beat_cyc_q[$];

    localparam logic [63:0] VA = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] VB = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W2 = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] W3 = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] BE_MERGED = 64'h1122_3344_FFFF_FFFF;

    ddram_responder_if bus();

    ddram_responder #(
        .MEM_AW(5), .CMD_DEPTH(4), .DAT_DEPTH(8), .RD_LAT(3)
    ) dut (
        .DDRAM_CLK    (clk),
        .DDRAM_RESET_N(rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DDRAM_DOUT_READY === 1'b1) begin
            beat_q.push_back(bus.DDRAM_DOUT);
            beat_cyc_q.push_back(cyc);
        end
        if (bus.DDRAM_BUSY === 1'b1) busy_seen = 1'b1;
    end

    function automatic logic [63:0] beat_at(input int i);
        if (i < beat_q.size()) return beat_q[i];
        return {64{1'bx}};
    endfunction

    function automatic int cyc_at(input int i);
        if (i < beat_cyc_q.size()) return beat_cyc_q[i];
        return -1;
    endfunction

    task automatic clear_beats();
        beat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.DDRAM_RD = 1'b0;
            bus.DDRAM_WE = 1'b0;
        end
    endtask

    // Present one command/beat and hold it until an edge with BUSY low takes it.
    task automatic drive(input logic rd, input logic we, input logic [28:0] addr,
                         input logic [7:0] bc, input logic [63:0] din,
                         input logic [7:0] be, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        bus.DDRAM_RD       = rd;
        bus.DDRAM_WE       = we;
        bus.DDRAM_ADDR     = addr;
        bus.DDRAM_BURSTCNT = bc;
        bus.DDRAM_DIN      = din;
        bus.DDRAM_BE       = be;
        while (bus.DDRAM_BUSY !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            fails++;
            $display("FAIL drive_timeout busy got=%b want=0", bus.DDRAM_BUSY);
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic wait_beats(input int n);
        int w;
        w = 0;
        while (beat_q.size() < n && w < 100) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.DDRAM_BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.DDRAM_BUSY); end
        checks++; if (bus.DDRAM_DOUT_READY !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", bus.DDRAM_DOUT_READY); end
        checks++; if (bus.DDRAM_DOUT !== 64'd0) begin fails++; $display("FAIL reset_dout got=%h want=0", bus.DDRAM_DOUT); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int acc;
        idle(3);
        clear_beats();
        drive(1'b0, 1'b1, 29'h10, 8'd1, 64'h1122_3344_5566_7788, 8'hFF, acc);
        idle(4);
        drive(1'b1, 1'b0, 29'h10, 8'd1, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(1);
        idle(4);
        checks++; if (beat_q.size() !== 1) begin fails++; $display("FAIL basic_count got=%0d want=1", beat_q.size()); end
        checks++; if (beat_at(0) !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL basic_data got=%h want=1122334455667788", beat_at(0)); end
        checks++; if (cyc_at(0) !== acc + 3) begin fails++; $display("FAIL basic_latency got=%0d want=%0d", cyc_at(0), acc + 3); end
        checks++; if (bus.DDRAM_DOUT !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL basic_dout_hold got=%h want=1122334455667788", bus.DDRAM_DOUT); end
        checks++; if (bus.DDRAM_DOUT_READY !== 1'b0) begin fails++; $display("FAIL basic_ready_low got=%b want=0", bus.DDRAM_DOUT_READY); end
    endtask

    // Partial byte write, read on the very next edge with BURSTCNT=0 (one beat).
    task automatic test_byte_enable();
        int acc;
        clear_beats();
        drive(1'b0, 1'b1, 29'h10, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, acc);
        drive(1'b1, 1'b0, 29'h10, 8'd0, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(1);
        idle(4);
        checks++; if (beat_q.size() !== 1) begin fails++; $display("FAIL be_count got=%0d want=1", beat_q.size()); end
        checks++; if (beat_at(0) !== BE_MERGED) begin fails++; $display("FAIL be_data got=%h want=%h", beat_at(0), BE_MERGED); end
    endtask

    task automatic test_wrap();
        int acc;
        drive(1'b0, 1'b1, 29'h1F, 8'd1, VA, 8'hFF, acc);
        drive(1'b0, 1'b1, 29'h20, 8'd1, VB, 8'hFF, acc);
        idle(4);
        clear_beats();
        drive(1'b1, 1'b0, 29'h1F, 8'd2, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(2);
        idle(4);
        checks++; if (beat_q.size() !== 2) begin fails++; $display("FAIL wrap_count got=%0d want=2", beat_q.size()); end
        checks++; if (beat_at(0) !== VA) begin fails++; $display("FAIL wrap_beat0 got=%h want=%h", beat_at(0), VA); end
        checks++; if (beat_at(1) !== VB) begin fails++; $display("FAIL wrap_beat1 got=%h want=%h", beat_at(1), VB); end
        checks++; if (cyc_at(0) !== acc + 3) begin fails++; $display("FAIL wrap_latency got=%0d want=%0d", cyc_at(0), acc + 3); end
        checks++; if (cyc_at(1) !== acc + 4) begin fails++; $display("FAIL wrap_contig got=%0d want=%0d", cyc_at(1), acc + 4); end
    endtask

    // Burst-4 write with idle gaps; continuation beats carry junk addr/count.
    task automatic test_gapped_write();
        int acc;
        logic [63:0] exp [4];
        exp[0] = W0; exp[1] = W1; exp[2] = W2; exp[3] = W3;
        clear_beats();
        drive(1'b0, 1'b1, 29'h40, 8'd4, W0, 8'hFF, acc);
        idle(1);
        drive(1'b0, 1'b1, 29'h1ABC, 8'd9, W1, 8'hFF, acc);
        idle(1);
        drive(1'b0, 1'b1, 29'h0003, 8'd1, W2, 8'hFF, acc);
        idle(1);
        drive(1'b0, 1'b1, 29'h0777, 8'd2, W3, 8'hFF, acc);
        drive(1'b1, 1'b0, 29'h40, 8'd4, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(4);
        idle(4);
        checks++; if (beat_q.size() !== 4) begin fails++; $display("FAIL gap_count got=%0d want=4", beat_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (beat_at(i) !== exp[i]) begin fails++; $display("FAIL gap_beat%0d got=%h want=%h", i, beat_at(i), exp[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (cyc_at(i) !== cyc_at(0) + i) begin fails++; $display("FAIL gap_contig%0d got=%0d want=%0d", i, cyc_at(i), cyc_at(0) + i); end
        end
    endtask

    // Burst-8 read keeps the engine busy while six burst-1 reads fill the queue.
    task automatic test_back_to_back();
        int acc, acc8;
        logic [63:0] exp [14];
        logic [28:0] sa [6];
        for (int i = 0; i < 8; i++) begin
            exp[i] = 64'hD000_0000_0000_0000 | 64'(i);
            drive(1'b0, 1'b1, 29'h08, 8'd8, exp[i], 8'hFF, acc);
        end
        exp[8] = W0; exp[9] = W1; exp[10] = W2; exp[11] = W3;
        exp[12] = BE_MERGED; exp[13] = VA;
        sa[0] = 29'h00; sa[1] = 29'h01; sa[2] = 29'h02;
        sa[3] = 29'h03; sa[4] = 29'h10; sa[5] = 29'h1F;
        idle(4);
        clear_beats();
        busy_seen = 1'b0;
        drive(1'b1, 1'b0, 29'h08, 8'd8, 64'd0, 8'h00, acc8);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, sa[i], 8'd1, 64'd0, 8'h00, acc);
        end
        idle(1);
        wait_beats(14);
        idle(4);
        checks++; if (beat_q.size() !== 14) begin fails++; $display("FAIL b2b_count got=%0d want=14", beat_q.size()); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (beat_at(i) !== exp[i]) begin fails++; $display("FAIL b2b_beat%0d got=%h want=%h", i, beat_at(i), exp[i]); end
            checks++;
            if (cyc_at(i) !== acc8 + 3 + i) begin fails++; $display("FAIL b2b_cyc%0d got=%0d want=%0d", i, cyc_at(i), acc8 + 3 + i); end
        end
        checks++; if (busy_seen !== 1'b1) begin fails++; $display("FAIL b2b_busy_seen got=%b want=1", busy_seen); end
        checks++; if (bus.DDRAM_BUSY !== 1'b0) begin fails++; $display("FAIL b2b_busy_end got=%b want=0", bus.DDRAM_BUSY); end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        idle(2);
        clear_beats();
        drive(1'b1, 1'b0, 29'h08, 8'd8, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.DDRAM_BUSY !== 1'b0) begin fails++; $display("FAIL mrst_busy got=%b want=0", bus.DDRAM_BUSY); end
        checks++; if (bus.DDRAM_DOUT_READY !== 1'b0) begin fails++; $display("FAIL mrst_ready got=%b want=0", bus.DDRAM_DOUT_READY); end
        checks++; if (bus.DDRAM_DOUT !== 64'd0) begin fails++; $display("FAIL mrst_dout got=%h want=0", bus.DDRAM_DOUT); end
        repeat (2) @(negedge clk);
        clear_beats();
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++; if (beat_q.size() !== 0) begin fails++; $display("FAIL mrst_no_beats got=%0d want=0", beat_q.size()); end
        drive(1'b1, 1'b0, 29'h10, 8'd1, 64'd0, 8'h00, acc);
        idle(1);
        wait_beats(1);
        idle(4);
        checks++; if (beat_q.size() !== 1) begin fails++; $display("FAIL mrst_read_count got=%0d want=1", beat_q.size()); end
        checks++; if (beat_at(0) !== BE_MERGED) begin fails++; $display("FAIL mrst_array_kept got=%h want=%h", beat_at(0), BE_MERGED); end
    endtask

    initial begin
        bus.DDRAM_RD       = 1'b0;
        bus.DDRAM_WE       = 1'b0;
        bus.DDRAM_ADDR     = 29'd0;
        bus.DDRAM_BURSTCNT = 8'd0;
        bus.DDRAM_DIN      = 64'd0;
        bus.DDRAM_BE       = 8'h00;
        test_reset();
        test_basic();
        test_byte_enable();
        test_wrap();
        test_gapped_write();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=completion");
        $fatal(1, "watchdog");
    end

endmodule
